alu8: RTL and testbench

- 8-bit integer ALU for the SM83-style (Game Boy) CPU datapath.
- Result and flag byte are combinational from operands, opcode and carry-in.
- A registered flag byte (F register image) captures flagsOut on write-enable for use by the sequencer and by DAA.
- Sits between the register file/operand muxes and the writeback bus.

---
 rtl/alu8_pkg.sv | 35 +++
 rtl/alu8_addsub.sv | 28 ++
 rtl/alu8.sv | 160 ++++++++++++++++
 tb/tb_alu8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// Shared opcode encodings, flag bit positions and flag packing for the alu8 slice.
package alu8_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SBC  = 4'b0011;
    localparam logic [3:0] OP_CP   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_RL   = 4'b1000;
    localparam logic [3:0] OP_RR   = 4'b1001;
    localparam logic [3:0] OP_BSL  = 4'b1010;
    localparam logic [3:0] OP_BSR  = 4'b1011;
    localparam logic [3:0] OP_SWAP = 4'b1100;
    localparam logic [3:0] OP_DAA  = 4'b1101;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                              input logic h, input logic c);
        logic [7:0] f;
        f         = 8'h00;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_H] = h;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu8_addsub.sv
// 8-bit adder/subtractor on one 9-bit datapath; half/carry read as borrows when sub=1.
module alu8_addsub (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       half,
    output logic       carry
);

    logic [7:0] b_eff;
    logic       c_eff;
    logic [8:0] sum9;
    logic [4:0] low5;

    // Subtraction is a + ~b + ~borrow_in; the raw carries come out inverted as borrows.
    always_comb begin
        b_eff = sub ? ~b : b;
        c_eff = sub ? ~cin : cin;
        sum9  = {1'b0, a} + {1'b0, b_eff} + {8'h00, c_eff};
        low5  = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'h0, c_eff};
        sum   = sum9[7:0];
        half  = low5[4] ^ sub;
        carry = sum9[8] ^ sub;
    end

endmodule

// File: rtl/alu8.sv
// SM83-style 8-bit ALU: combinational result/flags plus a registered F image.
// Define ALU8_DAA_EN to turn opcode 1101 into DAA driven by the registered flags.
module alu8
    import alu8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] regA,
    input  logic [7:0] regB,
    input  logic [3:0] opcode,
    input  logic       carryIn,
    input  logic       flagsWe,
    output logic [7:0] res,
    output logic [7:0] flagsOut,
    output logic [7:0] flagsReg
);

    logic       as_cin;
    logic       as_sub;
    logic [7:0] as_sum;
    logic       as_half;
    logic       as_carry;

    logic [7:0] res_c;
    logic       z_c;
    logic       n_c;
    logic       h_c;
    logic       c_c;
    logic       flags_en;

    logic [7:0] flags_reg_d;
    logic [7:0] flags_reg_q;

`ifdef ALU8_DAA_EN
    logic [7:0] daa_res;
    logic       daa_c;
`endif

    always_comb begin
        as_sub = (opcode == OP_SUB) || (opcode == OP_SBC) || (opcode == OP_CP);
        as_cin = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? carryIn : 1'b0;
    end

    alu8_addsub u_addsub (
        .a     (regA),
        .b     (regB),
        .cin   (as_cin),
        .sub   (as_sub),
        .sum   (as_sum),
        .half  (as_half),
        .carry (as_carry)
    );

`ifdef ALU8_DAA_EN
    // Correction uses the registered N/H/C of the preceding add/sub, not this cycle's flags.
    always_comb begin
        daa_res = regA;
        daa_c   = flags_reg_q[FLAG_C];
        if (!flags_reg_q[FLAG_N]) begin
            if (flags_reg_q[FLAG_H] || (regA[3:0] > 4'd9)) begin
                daa_res = daa_res + 8'h06;
            end
            if (flags_reg_q[FLAG_C] || (regA > 8'h99)) begin
                daa_res = daa_res + 8'h60;
                daa_c   = 1'b1;
            end else begin
                daa_c   = 1'b0;
            end
        end else begin
            if (flags_reg_q[FLAG_H]) begin
                daa_res = daa_res - 8'h06;
            end
            if (flags_reg_q[FLAG_C]) begin
                daa_res = daa_res - 8'h60;
            end
        end
    end
`endif

    always_comb begin
        res_c    = regA;
        n_c      = 1'b0;
        h_c      = 1'b0;
        c_c      = 1'b0;
        flags_en = 1'b1;
        z_c      = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                res_c = as_sum;
                h_c   = as_half;
                c_c   = as_carry;
            end
            OP_SUB, OP_SBC: begin
                res_c = as_sum;
                n_c   = 1'b1;
                h_c   = as_half;
                c_c   = as_carry;
            end
            OP_CP: begin
                n_c   = 1'b1;
                h_c   = as_half;
                c_c   = as_carry;
            end
            OP_AND: begin
                res_c = regA & regB;
                h_c   = 1'b1;
            end
            OP_OR:   res_c = regA | regB;
            OP_XOR:  res_c = regA ^ regB;
            OP_RL: begin
                res_c = {regA[6:0], carryIn};
                c_c   = regA[7];
            end
            OP_RR: begin
                res_c = {carryIn, regA[7:1]};
                c_c   = regA[0];
            end
            OP_BSL: begin
                res_c = {regA[6:0], 1'b0};
                c_c   = regA[7];
            end
            OP_BSR: begin
                res_c = {1'b0, regA[7:1]};
                c_c   = regA[0];
            end
            OP_SWAP: res_c = {regA[3:0], regA[7:4]};
`ifdef ALU8_DAA_EN
            OP_DAA: begin
                res_c = daa_res;
                n_c   = flags_reg_q[FLAG_N];
                c_c   = daa_c;
            end
`endif
            default: flags_en = 1'b0;
        endcase
        // CP leaves res=A but its Z still reflects the compare (A-B).
        z_c = (opcode == OP_CP) ? (as_sum == 8'h00) : (res_c == 8'h00);
    end

    assign res      = res_c;
    assign flagsOut = flags_en ? pack_flags(z_c, n_c, h_c, c_c) : 8'h00;

    always_comb begin
        flags_reg_d = flags_reg_q;
        if (flagsWe) begin
            flags_reg_d = flagsOut;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg_q <= 8'h00;
        end else begin
            flags_reg_q <= flags_reg_d;
        end
    end

    assign flagsReg = flags_reg_q;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed vectors, register path and randomized sweeps.
module tb_alu8;

    logic       clk;
    logic       rst_n;
    logic [7:0] regA;
    logic [7:0] regB;
    logic [3:0] opcode;
    logic       carryIn;
    logic       flagsWe;
    logic [7:0] res;
    logic [7:0] flagsOut;
    logic [7:0] flagsReg;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_freg = 8'h00;

    alu8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regA     (regA),
        .regB     (regB),
        .opcode   (opcode),
        .carryIn  (carryIn),
        .flagsWe  (flagsWe),
        .res      (res),
        .flagsOut (flagsOut),
        .flagsReg (flagsReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic rules, using plain integers.
    task automatic model(input int op, input int a, input int b, input int cin,
                         input logic [7:0] freg, output logic [7:0] r, output logic [7:0] f);
        int v;
        int z, n, h, c, valid;
        v = a; n = 0; h = 0; c = 0; valid = 1;
        case (op)
            0, 1: begin
                if (op == 0) cin = 0;
                v = a + b + cin;
                h = ((a % 16) + (b % 16) + cin) > 15;
                c = v > 255;
            end
            2, 3, 4: begin
                if (op != 3) cin = 0;
                v = a - b - cin;
                n = 1;
                h = (a % 16) < ((b % 16) + cin);
                c = a < (b + cin);
            end
            5: begin v = a & b; h = 1; end
            6: v = a | b;
            7: v = a ^ b;
            8:  begin v = a * 2 + cin;           c = a / 128; end
            9:  begin v = cin * 128 + a / 2;     c = a % 2;   end
            10: begin v = a * 2;                 c = a / 128; end
            11: begin v = a / 2;                 c = a % 2;   end
            12: v = (a % 16) * 16 + a / 16;
`ifdef ALU8_DAA_EN
            13: begin
                n = freg[6];
                if (!freg[6]) begin
                    if (freg[5] || (a % 16) > 9) v = v + 6;
                    if (freg[4] || a > 153) begin v = v + 96; c = 1; end
                end else begin
                    if (freg[5]) v = v - 6;
                    if (freg[4]) v = v - 96;
                    c = freg[4];
                end
            end
`endif
            default: valid = 0;
        endcase
        v = ((v % 256) + 256) % 256;
        z = (op == 4) ? (((a - b + 256) % 256) == 0) : (v == 0);
        r = (op == 4) ? 8'(a) : 8'(v);
        f = valid ? 8'({z[0], n[0], h[0], c[0], 4'b0000}) : 8'h00;
    endtask

    task automatic drive(input int op, input int a, input int b, input int cin);
        opcode  = 4'(op);
        regA    = 8'(a);
        regB    = 8'(b);
        carryIn = cin[0];
    endtask

    task automatic apply_check(input string tag, input int op, input int a, input int b,
                               input int cin);
        logic [7:0] er, ef;
        drive(op, a, b, cin);
        #1;
        model(op, a, b, cin, exp_freg, er, ef);
        check({tag, ".res"}, res, er);
        check({tag, ".flags"}, flagsOut, ef);
    endtask

    initial begin
        rst_n   = 1'b0;
        flagsWe = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        check("reset.flagsReg", flagsReg, 8'h00);

        // Directed vectors with literal expectations.
        drive(1, 8'h0F, 8'h01, 1); #1; check("adc.res", res, 8'h11); check("adc.flags", flagsOut, 8'h20);
        drive(0, 8'hFF, 8'h01, 0); #1; check("add.res", res, 8'h00); check("add.flags", flagsOut, 8'hB0);
        drive(3, 8'h10, 8'h01, 1); #1; check("sbc.res", res, 8'h0E); check("sbc.flags", flagsOut, 8'h60);
        drive(2, 8'h00, 8'h01, 1); #1; check("sub.res", res, 8'hFF); check("sub.flags", flagsOut, 8'h70);
        drive(4, 8'h42, 8'h42, 0); #1; check("cp.res", res, 8'h42);  check("cp.flags", flagsOut, 8'hC0);
        drive(5, 8'hF0, 8'h0F, 0); #1; check("and.res", res, 8'h00); check("and.flags", flagsOut, 8'hA0);
        drive(8, 8'h80, 8'h55, 0); #1; check("rl.res", res, 8'h00);  check("rl.flags", flagsOut, 8'h90);
        drive(9, 8'h01, 8'h55, 1); #1; check("rr.res", res, 8'h80);  check("rr.flags", flagsOut, 8'h10);
        drive(12, 8'hF0, 8'h00, 0); #1; check("swap.res", res, 8'h0F); check("swap.flags", flagsOut, 8'h00);
        drive(10, 8'h81, 8'h00, 1); #1; check("bsl.res", res, 8'h02); check("bsl.flags", flagsOut, 8'h10);
        drive(11, 8'h01, 8'h00, 1); #1; check("bsr.res", res, 8'h00); check("bsr.flags", flagsOut, 8'h90);
        drive(14, 8'h00, 8'hFF, 1); #1; check("unused.res", res, 8'h00); check("unused.flags", flagsOut, 8'h00);
`ifndef ALU8_DAA_EN
        drive(13, 8'h99, 8'h01, 1); #1; check("op13.res", res, 8'h99); check("op13.flags", flagsOut, 8'h00);
`endif

        // Reset held low across an edge must win over flagsWe.
        drive(0, 8'hFF, 8'h01, 0);
        flagsWe = 1'b1;
        @(posedge clk); #1;
        check("reset_over_we", flagsReg, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_freg = 8'hB0;
        check("we.load", flagsReg, exp_freg);

        @(negedge clk);
        flagsWe = 1'b0;
        drive(12, 8'hF0, 8'h00, 0);
        @(posedge clk); #1;
        check("we0.hold", flagsReg, exp_freg);

        @(negedge clk);
        flagsWe = 1'b1;
        drive(2, 8'h00, 8'h01, 0);
        @(posedge clk); #1;
        exp_freg = 8'h70;
        check("we.load2", flagsReg, exp_freg);

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_freg = 8'h00;
        check("midcycle_reset", flagsReg, exp_freg);
        #1;
        rst_n   = 1'b1;
        flagsWe = 1'b0;
        @(posedge clk); #1;
        check("post_reset_hold", flagsReg, exp_freg);

        // Randomized ADC/SBC sweeps with carry-in set.
        for (int i = 0; i < 100; i++) begin
            apply_check("rand_adc", 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end
        for (int i = 0; i < 100; i++) begin
            apply_check("rand_sbc", 3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end

        // Randomized sweep over every opcode, occasionally reloading flagsReg.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] er, ef;
            int op, a, b, cin;
            op  = int'($urandom_range(0, 15));
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(0, 255));
            cin = int'($urandom_range(0, 1));
            @(negedge clk);
            drive(op, a, b, cin);
            flagsWe = ($urandom_range(0, 3) == 0);
            #1;
            model(op, a, b, cin, exp_freg, er, ef);
            check("sweep.res", res, er);
            check("sweep.flags", flagsOut, ef);
            @(posedge clk); #1;
            if (flagsWe) exp_freg = ef;
            check("sweep.flagsReg", flagsReg, exp_freg);
        end
        flagsWe = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
